// File: rtl/dornersito_uart_rx.sv
// dornersito_uart_rx: oversampling 8N1 UART receiver with a small FIFO and valid/ready output.
// Define DORNERSITO_UART_PARITY_EN for 8E1 frames with even-parity checking.
module dornersito_uart_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic                        rx,
    output logic [7:0]                  out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overflow,
    output logic                        busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH = (PW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] FULL = 16'(CLKS_PER_BIT);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4, BREAK = 3'd5;
`ifdef DORNERSITO_UART_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] AFTER_DATA = PARITY;
`else
    localparam logic [2:0] AFTER_DATA = STOP;
`endif

    logic          rx_m, rx_s, rx_p;
    logic [2:0]    state;
    logic [15:0]   tmr;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic          expire, stop_hit, bad, push_req, pop, push;

    assign expire     = (tmr == 16'd1);
    assign stop_hit   = (state == STOP) && expire;
    assign push_req   = ena && stop_hit && rx_s && !bad;
    assign pop        = (count != '0) && out_ready;
    // a pop on the same edge frees the slot, so a full FIFO still accepts the byte
    assign push       = push_req && ((count != DEPTH) || pop);
    assign out_valid  = (count != '0);
    assign out_data   = out_valid ? mem[rd_ptr] : 8'h00;
    assign fifo_count = count;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {rx_m, rx_s, rx_p} <= 3'b111;
        else {rx_m, rx_s, rx_p} <= {rx, rx_m, rx_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tmr   <= '0;
            idx   <= '0;
            shift <= '0;
        end else if (!ena) begin
            state <= IDLE;
        end else begin
            if (state != IDLE) tmr <= expire ? FULL : tmr - 16'd1;
            case (state)
                IDLE:  if (rx_p && !rx_s) begin
                    state <= START;
                    tmr   <= HALF;
                end
                START: if (expire) begin
                    state <= rx_s ? IDLE : DATA;
                    idx   <= '0;
                end
                DATA:  if (expire) begin
                    shift <= {rx_s, shift[7:1]};
                    idx   <= idx + 3'd1;
                    if (idx == 3'd7) state <= AFTER_DATA;
                end
`ifdef DORNERSITO_UART_PARITY_EN
                PARITY: if (expire) state <= STOP;
`endif
                STOP:  if (expire) state <= rx_s ? IDLE : BREAK;
                BREAK: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DORNERSITO_UART_PARITY_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) bad <= 1'b0;
        else if (state == PARITY && expire) bad <= rx_s ^ (^shift);
    // reported at the stop sample so a framing error takes precedence
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) parity_err <= 1'b0;
        else parity_err <= ena && stop_hit && rx_s && bad;
`else
    assign bad        = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else if (!ena) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= stop_hit && !rx_s;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW + 1)'(push) - (PW + 1)'(pop);
            if (push_req && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= shift;
endmodule

// File: tb/tb_dornersito_uart_rx.sv
// tb_dornersito_uart_rx: table-driven and randomized checks of dornersito_uart_rx
// against a cycle-level queue model of the receive FIFO.
module tb_dornersito_uart_rx;
    localparam int C = 16, D = 4, H = C / 2;
`ifdef DORNERSITO_UART_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB = PAR ? 11 : 10;
    // stop-sample edge after the start bit is driven: two sync flops plus the edge-detect cycle
    localparam int LAT = 3 + H + (NB - 1) * C;

    logic       clk = 1'b0, rst_n, ena, rx, out_ready;
    logic [7:0] out_data;
    logic       out_valid, frame_err, parity_err, overflow, busy;
    logic [2:0] fifo_count;

    dornersito_uart_rx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_count(fifo_count), .frame_err(frame_err), .parity_err(parity_err),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int at; logic [7:0] d; bit ok; bit ferr; bit perr; } ev_t;
    typedef struct { logic [7:0] d; bit stop; int hold; int exp_count; logic [7:0] exp_data; int exp_ferr; } vec_t;

    ev_t        ev[$];
    bit         stream[$];
    logic [7:0] q[$];
    logic [7:0] exp_q[$];
    bit         ovf_m, fe_m, pe_m;
    int         n_tests = 0, n_fail = 0, fe_seen;
    vec_t       tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_frame(input logic [7:0] d, input bit stop, input bit flip, input int hold, input int gap);
        ev_t e;
        e.at   = stream.size() + LAT;
        e.d    = d;
        e.ferr = !stop;
        e.perr = PAR && stop && flip;
        e.ok   = stop && !e.perr;
        ev.push_back(e);
        repeat (C) stream.push_back(1'b0);
        for (int b = 0; b < 8; b++) repeat (C) stream.push_back(d[b]);
        if (PAR) repeat (C) stream.push_back(^d ^ flip);
        repeat (C) stream.push_back(stop);
        repeat (hold) stream.push_back(1'b0);
        repeat (gap) stream.push_back(1'b1);
    endtask

    // mode: 0 ready low, 1 ready high, 2 random, 3 ready only on a push edge while full
    task automatic play(input int mode);
        @(posedge clk); #1;
        ena = 1'b0; rx = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        ena = 1'b1;
        q.delete(); ovf_m = 0; fe_m = 0; pe_m = 0; fe_seen = 0;
        for (int i = 0; i < stream.size(); i++) begin
            bit due, pop;
            due = ev.size() != 0 && ev[0].at == i + 1;
            rx = stream[i];
            out_ready = mode == 1 ? 1'b1 : mode == 2 ? ($urandom_range(0, 2) == 0) :
                        mode == 3 ? (due && q.size() == D) : 1'b0;
            @(negedge clk);
            chk("fifo_count", fifo_count, q.size());
            chk("out_valid", out_valid, q.size() != 0);
            chk("out_data", out_data, q.size() != 0 ? q[0] : 8'h00);
            chk("overflow", overflow, ovf_m);
            chk("frame_err", frame_err, fe_m);
            chk("parity_err", parity_err, pe_m);
            fe_seen += int'(frame_err);
            pop = q.size() != 0 && out_ready;
            if (pop) void'(q.pop_front());
            fe_m = 0; pe_m = 0;
            if (due) begin
                if (ev[0].ok) begin
                    if (q.size() < D) q.push_back(ev[0].d);
                    else ovf_m = 1;
                end
                fe_m = ev[0].ferr;
                pe_m = ev[0].perr;
                void'(ev.pop_front());
            end
            @(posedge clk); #1;
        end
        stream.delete();
        ev.delete();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        foreach (exp_q[k]) begin
            @(negedge clk);
            chk("drain_valid", out_valid, 1);
            chk("drain_data", out_data, exp_q[k]);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("drain_empty_valid", out_valid, 0);
        chk("drain_empty_count", fifo_count, 0);
        out_ready = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_count"}, fifo_count, 0);
        chk({tag, "_ferr"}, frame_err, 0);
        chk({tag, "_perr"}, parity_err, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 0, 1, 8'hA5, 0};
        tbl[1] = '{8'h00, 1'b1, 0, 1, 8'h00, 0};
        tbl[2] = '{8'hFF, 1'b1, 0, 1, 8'hFF, 0};
        tbl[3] = '{8'h55, 1'b0, 40, 0, 8'h00, 1};
        tbl[4] = '{8'h3C, 1'b1, 0, 1, 8'h3C, 0};
        tbl[5] = '{8'h80, 1'b0, 0, 0, 8'h00, 1};
        rst_n = 1'b0; ena = 1'b0; rx = 1'b1; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // asynchronous reset in the middle of a frame, with data and overflow pending
        for (int k = 0; k < 5; k++) add_frame(8'h11 + 8'(k), 1'b1, 1'b0, 0, 0);
        repeat (3 * C) stream.push_back(1'b0);
        play(0);
        chk("prereset_busy", busy, 1);
        chk("prereset_valid", out_valid, 1);
        chk("prereset_ovf", overflow, 1);
        #2 rst_n = 1'b0; rx = 1'b1;
        #1 chk_zero("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        foreach (tbl[t]) begin
            add_frame(tbl[t].d, tbl[t].stop, 1'b0, tbl[t].hold, 20);
            play(0);
            chk("tbl_count", fifo_count, tbl[t].exp_count);
            chk("tbl_data", out_data, tbl[t].exp_data);
            chk("tbl_ferr_pulses", fe_seen, tbl[t].exp_ferr);
            chk("tbl_busy", busy, 0);
        end

        add_frame(8'h00, 1'b1, 1'b0, 0, 0);
        add_frame(8'hFF, 1'b1, 1'b0, 0, 0);
        add_frame(8'h3C, 1'b1, 1'b0, 0, 20);
        play(0);
        chk("b2b_count", fifo_count, 3);
        exp_q = '{8'h00, 8'hFF, 8'h3C};
        drain();

        for (int k = 1; k <= 6; k++) add_frame(8'(k), 1'b1, 1'b0, 0, 0);
        repeat (20) stream.push_back(1'b1);
        play(0);
        chk("ovf_count", fifo_count, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", out_data, 8'h01);
        ena = 1'b0;
        @(posedge clk); #1 ena = 1'b1;
        @(negedge clk);
        chk("flush_count", fifo_count, 0);
        chk("flush_ovf", overflow, 0);
        chk("flush_valid", out_valid, 0);

        repeat (20) stream.push_back(1'b1);
        repeat (4) stream.push_back(1'b0);
        repeat (30) stream.push_back(1'b1);
        play(0);
        chk("glitch_count", fifo_count, 0);
        chk("glitch_busy", busy, 0);
        chk("glitch_ferr_pulses", fe_seen, 0);

        add_frame(8'h55, 1'b0, 1'b0, 40, 0);
        play(0);
        chk("break_busy", busy, 1);
        chk("break_ferr_pulses", fe_seen, 1);
        chk("break_count", fifo_count, 0);
        rx = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) chk("break_busy_sync", busy, 1);
        @(posedge clk);
        @(negedge clk) chk("break_idle", busy, 0);

        for (int k = 1; k <= 4; k++) add_frame(8'(k), 1'b1, 1'b0, 0, 5);
        add_frame(8'h77, 1'b1, 1'b0, 0, 20);
        play(3);
        chk("fullpop_count", fifo_count, 4);
        chk("fullpop_ovf", overflow, 0);
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h77};
        drain();

        add_frame(8'h03, 1'b1, 1'b0, 0, 5);
        add_frame(8'h03, 1'b1, 1'b1, 0, 20);
        play(0);
        chk("parity_count", fifo_count, PAR ? 1 : 2);

        for (int b = 0; b < 3; b++) begin
            for (int f = 0; f < 15; f++) begin
                bit st;
                if ($urandom_range(0, 5) == 0) begin
                    repeat ($urandom_range(2, 5)) stream.push_back(1'b0);
                    repeat (10) stream.push_back(1'b1);
                end
                st = $urandom_range(0, 9) != 0;
                add_frame(8'($urandom), st, $urandom_range(0, 7) == 0,
                          st ? 0 : int'($urandom_range(0, 30)),
                          st ? int'($urandom_range(0, 12)) : int'($urandom_range(4, 12)));
            end
            repeat (20) stream.push_back(1'b1);
            play(2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
